// File: rtl/rv_mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv_mem_pkg: shared types and constants for the fetch/data memory arbiter.
// Revision 1.0
// ----------------------------------------------------------------------------
package rv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_GNT = 2'd1,
      WAIT_RSP = 2'd2
   } state_t;

   localparam logic OWN_FETCH = 1'b0;
   localparam logic OWN_DATA  = 1'b1;

   localparam int AW_DEF = 32;
   localparam int DW_DEF = 32;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter_if: fetch, data and memory-side buses of the arbiter.
// Revision 1.0
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_gnt;
   logic          i_rvalid;
   logic [DW-1:0] i_rdata;
   logic          i_err;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          d_err;

   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_gnt;
   logic          m_rvalid;
   logic [DW-1:0] m_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_gnt, m_rvalid, m_rdata,
      output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
             m_req, m_we, m_addr, m_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_gnt, m_rvalid, m_rdata,
      input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
             m_req, m_we, m_addr, m_wdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_arb_sel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_sel: data-priority winner select with fetch anti-starvation count.
// Revision 1.0
// ----------------------------------------------------------------------------
module mem_arb_sel #(
   parameter int MAX_DBURST = 4
) (
   input  logic       en,
   input  logic       i_req,
   input  logic       d_req,
   input  logic [3:0] starve_q,
   output logic       gnt_fetch,
   output logic       gnt_data,
   output logic [3:0] starve_d
);

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_DBURST);

   always_comb begin
      gnt_fetch = 1'b0;
      gnt_data  = 1'b0;
      starve_d  = starve_q;
      if (en) begin
         if (d_req && (!i_req || starve_q != BURST_LIMIT)) begin
            gnt_data = 1'b1;
            // Only a data grant that actually overtakes a waiting fetch counts.
            starve_d = i_req ? 4'(starve_q + 4'd1) : 4'd0;
         end else if (i_req) begin
            gnt_fetch = 1'b1;
            starve_d  = 4'd0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter: shares one single-ported memory between fetch and data.
// Revision 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter
   import rv_mem_pkg::*;
#(
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int MAX_DBURST = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic             clk,
   input  logic             reset,
   mem_port_arbiter_if.slave bus
);

   localparam int             TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]  TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t          state_q, state_d;
   logic            owner_q, owner_d;
   logic [3:0]      starve_q, starve_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            tmo_pulse_q, tmo_pulse_d;
   logic            m_req_q, m_req_d;
   logic            m_we_q, m_we_d;
   logic [AW-1:0]   m_addr_q, m_addr_d;
   logic [DW-1:0]   m_wdata_q, m_wdata_d;

   logic            gnt_fetch, gnt_data;
   logic            mem_gnt, mem_rsp, fetch_own;
   logic [3:0]      starve_sel;

   mem_arb_sel #(
      .MAX_DBURST (MAX_DBURST)
   ) u_sel (
      .en        (state_q == IDLE),
      .i_req     (bus.i_req),
      .d_req     (bus.d_req),
      .starve_q  (starve_q),
      .gnt_fetch (gnt_fetch),
      .gnt_data  (gnt_data),
      .starve_d  (starve_sel)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      starve_d    = starve_sel;
      tmo_d       = tmo_q;
      tmo_pulse_d = 1'b0;
      m_req_d     = m_req_q;
      m_we_d      = m_we_q;
      m_addr_d    = m_addr_q;
      m_wdata_d   = m_wdata_q;
      case (state_q)
         IDLE: begin
            if (gnt_fetch || gnt_data) begin
               owner_d   = gnt_data ? OWN_DATA : OWN_FETCH;
               m_req_d   = 1'b1;
               m_we_d    = gnt_data && bus.d_we;
               m_addr_d  = gnt_data ? bus.d_addr : bus.i_addr;
               m_wdata_d = gnt_data ? bus.d_wdata : '0;
               state_d   = WAIT_GNT;
            end
         end
         WAIT_GNT: begin
            if (bus.m_gnt) begin
               m_req_d = 1'b0;
               tmo_d   = '0;
               state_d = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (bus.m_rvalid) begin
               state_d = IDLE;
            end else if (TIMEOUT > 0) begin
               if (tmo_q == TMO_LAST) begin
                  tmo_pulse_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  tmo_d = TW'(tmo_q + 1'b1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_FETCH;
         starve_q    <= 4'd0;
         tmo_q       <= '0;
         tmo_pulse_q <= 1'b0;
         m_req_q     <= 1'b0;
         m_we_q      <= 1'b0;
         m_addr_q    <= '0;
         m_wdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         tmo_pulse_q <= tmo_pulse_d;
         m_req_q     <= m_req_d;
         m_we_q      <= m_we_d;
         m_addr_q    <= m_addr_d;
         m_wdata_q   <= m_wdata_d;
      end
   end

   // Responses are only honoured in WAIT_RSP, so stray or late m_rvalid never leaks out.
   assign mem_gnt   = (state_q == WAIT_GNT) && bus.m_gnt;
   assign mem_rsp   = (state_q == WAIT_RSP) && bus.m_rvalid;
   assign fetch_own = (owner_q == OWN_FETCH);

   assign bus.m_req    = m_req_q;
   assign bus.m_we     = m_we_q;
   assign bus.m_addr   = m_addr_q;
   assign bus.m_wdata  = m_wdata_q;

   assign bus.i_gnt    = mem_gnt && fetch_own;
   assign bus.d_gnt    = mem_gnt && !fetch_own;
   assign bus.i_rvalid = (mem_rsp || tmo_pulse_q) && fetch_own;
   assign bus.d_rvalid = (mem_rsp || tmo_pulse_q) && !fetch_own;
   assign bus.i_err    = tmo_pulse_q && fetch_own;
   assign bus.d_err    = tmo_pulse_q && !fetch_own;
   assign bus.i_rdata  = (mem_rsp && fetch_own && !m_we_q) ? bus.m_rdata : '0;
   assign bus.d_rdata  = (mem_rsp && !fetch_own && !m_we_q) ? bus.m_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_port_arbiter #(
      .AW         (32),
      .DW         (32),
      .MAX_DBURST (2),
      .TIMEOUT    (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are sampled 1ns later.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   logic        exp_data [6];
   logic        got_data;

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset         = 1'b0;
      bus.i_req     = 1'b0;
      bus.i_addr    = '0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.m_gnt     = 1'b0;
      bus.m_rvalid  = 1'b0;
      bus.m_rdata   = '0;

      // Reset state
      cyc(); settle();
      check("rst_m_req", 32'(bus.m_req), 32'd0);
      check("rst_m_addr", bus.m_addr, 32'd0);
      check("rst_rvalid", 32'({bus.i_rvalid, bus.d_rvalid, bus.i_gnt, bus.d_gnt}), 32'd0);
      reset = 1'b1;

      // 1. Single fetch, zero-wait memory
      cyc(); bus.i_req = 1'b1; bus.i_addr = 32'h100; settle();
      check("t1_idle_m_req", 32'(bus.m_req), 32'd0);
      cyc(); bus.m_gnt = 1'b1; settle();
      check("t1_m_req", 32'(bus.m_req), 32'd1);
      check("t1_m_addr", bus.m_addr, 32'h100);
      check("t1_m_we", 32'(bus.m_we), 32'd0);
      check("t1_gnt", 32'({bus.i_gnt, bus.d_gnt}), 32'b10);
      cyc(); bus.i_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hDEADBEEF; settle();
      check("t1_m_req_drop", 32'(bus.m_req), 32'd0);
      check("t1_i_gnt_1cyc", 32'(bus.i_gnt), 32'd0);
      check("t1_i_rvalid", 32'(bus.i_rvalid), 32'd1);
      check("t1_i_rdata", bus.i_rdata, 32'hDEADBEEF);
      check("t1_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      cyc(); bus.m_rvalid = 1'b0; settle();
      check("t1_i_rvalid_1cyc", 32'(bus.i_rvalid), 32'd0);

      // 2. Contention with MAX_DBURST=2: expected D,D,I,D,D,I
      exp_data[0] = 1'b1; exp_data[1] = 1'b1; exp_data[2] = 1'b0;
      exp_data[3] = 1'b1; exp_data[4] = 1'b1; exp_data[5] = 1'b0;
      bus.i_addr = 32'h200; bus.d_addr = 32'h300; bus.d_we = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cyc(); bus.i_req = 1'b1; bus.d_req = 1'b1; bus.m_rvalid = 1'b0;
         cyc(); bus.m_gnt = 1'b1; settle();
         got_data = bus.d_gnt;
         check($sformatf("t2_gnt%0d", k), 32'({bus.d_gnt, bus.i_gnt}),
               exp_data[k] ? 32'b10 : 32'b01);
         check($sformatf("t2_addr%0d", k), bus.m_addr, exp_data[k] ? 32'h300 : 32'h200);
         cyc(); bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hA000 + 32'(k); settle();
         check($sformatf("t2_rvalid%0d", k), 32'({bus.d_rvalid, bus.i_rvalid}),
               got_data ? 32'b10 : 32'b01);
      end
      cyc(); bus.i_req = 1'b0; bus.d_req = 1'b0; bus.m_rvalid = 1'b0;

      // 3. Store with three wait states on m_gnt
      cyc(); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'h12345678;
      for (int k = 0; k < 4; k++) begin
         cyc(); bus.m_gnt = (k == 3); settle();
         check($sformatf("t3_m_req%0d", k), 32'({bus.m_req, bus.m_we}), 32'b11);
         check($sformatf("t3_m_addr%0d", k), bus.m_addr, 32'h2000);
         check($sformatf("t3_m_wdata%0d", k), bus.m_wdata, 32'h12345678);
         check($sformatf("t3_d_gnt%0d", k), 32'(bus.d_gnt), (k == 3) ? 32'd1 : 32'd0);
      end
      cyc(); bus.d_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h5555AAAA; settle();
      check("t3_ack", 32'({bus.d_rvalid, bus.d_err, bus.i_rvalid}), 32'b100);
      check("t3_d_rdata", bus.d_rdata, 32'd0);
      cyc(); bus.m_rvalid = 1'b0; bus.d_we = 1'b0;

      // 4. Load timeout after 8 WAIT_RSP cycles, then a late m_rvalid
      cyc(); bus.d_req = 1'b1; bus.d_addr = 32'h40;
      cyc(); bus.m_gnt = 1'b1; settle();
      check("t4_d_gnt", 32'(bus.d_gnt), 32'd1);
      bus.m_rdata = 32'hAAAA5555;
      for (int k = 0; k < 8; k++) begin
         cyc(); bus.d_req = 1'b0; bus.m_gnt = 1'b0; settle();
         check($sformatf("t4_wait%0d", k), 32'({bus.d_rvalid, bus.i_rvalid}), 32'd0);
      end
      cyc(); settle();
      check("t4_tmo", 32'({bus.d_rvalid, bus.d_err, bus.i_rvalid, bus.i_err}), 32'b1100);
      check("t4_tmo_rdata", bus.d_rdata, 32'd0);
      cyc(); settle();
      check("t4_tmo_1cyc", 32'(bus.d_rvalid), 32'd0);
      cyc(); bus.m_rvalid = 1'b1; settle();
      check("t4_late", 32'({bus.d_rvalid, bus.i_rvalid, bus.d_err}), 32'd0);
      cyc(); bus.m_rvalid = 1'b0;

      // 5. Asynchronous reset during WAIT_RSP
      cyc(); bus.i_req = 1'b1; bus.i_addr = 32'h500;
      cyc(); bus.m_gnt = 1'b1; settle();
      check("t5_i_gnt", 32'(bus.i_gnt), 32'd1);
      cyc(); bus.i_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h77;
      #2 reset = 1'b0;
      #1;
      check("t5_rst_outs", 32'({bus.m_req, bus.m_we, bus.i_rvalid, bus.d_rvalid, bus.i_gnt}), 32'd0);
      check("t5_rst_addr", bus.m_addr, 32'd0);
      #1 reset = 1'b1;
      cyc(); settle();
      check("t5_stray", 32'({bus.i_rvalid, bus.d_rvalid}), 32'd0);
      cyc(); bus.m_rvalid = 1'b0; bus.i_req = 1'b1; bus.i_addr = 32'h600; bus.d_req = 1'b1; bus.d_addr = 32'h700;
      // starve_cnt is 0 after reset, so data wins first, then data again, then fetch
      for (int k = 0; k < 3; k++) begin
         cyc(); bus.m_gnt = 1'b1; settle();
         check($sformatf("t5_gnt%0d", k), 32'({bus.d_gnt, bus.i_gnt}), (k == 2) ? 32'b01 : 32'b10);
         cyc(); bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1;
         if (k == 2) begin
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
         end
         settle();
         check($sformatf("t5_rsp%0d", k), 32'({bus.d_rvalid, bus.i_rvalid}), (k == 2) ? 32'b01 : 32'b10);
         cyc(); bus.m_rvalid = 1'b0;
      end

      cyc();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
